// File: rtl/ttl_138_cs_sequencer.sv
// Chip-select sequencer and two-way arbiter driving a 74138-style 3-to-8 decoder.
// Two requesters share the decoder. The sequencer drives select and enables with
// programmable address setup, strobe width per region and hold, then pulses an ack
// back to the requester that owned the transaction.
module ttl_138_cs_sequencer #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned HOLD_CYC   = 1,
  parameter logic [23:0] WAIT_TABLE = 24'h000000,
  parameter int unsigned CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [2:0] sel0,
  output logic       ack0,
  input  logic       req1,
  input  logic [2:0] sel1,
  output logic       ack1,
  output logic       dec_g1,
  output logic       dec_g2a_n,
  output logic       dec_g2b_n,
  output logic [2:0] dec_a,
  output logic       grant_id,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Counter reload values: each counts down to zero on the last cycle of its phase.
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'((HOLD_CYC > 1) ? HOLD_CYC - 1 : 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_grant;
  logic             win;
  logic [2:0]       win_sel;

  // Strobe reload for a region: its 3-bit wait field (strobe lasts field+1 cycles).
  function automatic logic [CNT_W-1:0] strobe_load(input logic [2:0] region);
    logic [2:0] field;
    field = 3'd0;
    for (int r = 0; r < 8; r++) begin
      if (region == 3'(r)) field = WAIT_TABLE[3*r +: 3];
    end
    return CNT_W'(field);
  endfunction

  // Arbitration: a lone request wins; on contention the requester not served last wins.
  always_comb begin
    win     = 1'b0;
    win_sel = sel0;
    if (req0 && req1) begin
      win = ~last_grant;
    end else begin
      win = req1;
    end
    if (win) win_sel = sel1;
  end

  // Sequencer FSM with registered decoder controls, ack pulses and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      busy       <= 1'b0;
      dec_g1     <= 1'b0;
      dec_g2a_n  <= 1'b1;
      dec_g2b_n  <= 1'b1;
      dec_a      <= 3'd0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant_id   <= win;
            last_grant <= win;
            dec_a      <= win_sel;
            busy       <= 1'b1;
            dec_g1     <= 1'b1;
            if (SETUP_CYC > 0) begin
              state <= SETUP;
              cnt   <= SETUP_LOAD;
            end else begin
              state     <= STROBE;
              cnt       <= strobe_load(win_sel);
              dec_g2a_n <= 1'b0;
              dec_g2b_n <= 1'b0;
            end
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state     <= STROBE;
            cnt       <= strobe_load(dec_a);
            dec_g2a_n <= 1'b0;
            dec_g2b_n <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            state     <= HOLD;
            cnt       <= HOLD_LOAD;
            dec_g2a_n <= 1'b1;
            dec_g2b_n <= 1'b1;
            // Single-cycle hold: the first hold cycle is also the ack cycle.
            if (HOLD_LOAD == '0) begin
              ack0 <= ~grant_id;
              ack1 <= grant_id;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state  <= IDLE;
            busy   <= 1'b0;
            dec_g1 <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              ack0 <= ~grant_id;
              ack1 <= grant_id;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ttl_138_cs_sequencer.md
Name: ttl_138_cs_sequencer

Overview:
Clocked chip-select sequencer and arbiter in front of a 3-to-8 active-low decoder (74138-style: G1, G2An, G2Bn, C/B/A).
- Shares the decoder between two bus requesters, e.g. main CPU and sub CPU/DMA.
- Drives decoder select and enables with programmable address setup, strobe width and hold.
- Returns a one-cycle acknowledge to the granted requester.

Parameters:
SETUP_CYC, 1, cycles select is stable with G1 high before strobe (0 = skip SETUP)
HOLD_CYC, 1, cycles after strobe with G1 held high (min 1)
WAIT_TABLE, 24'h000000, packed 3-bit strobe length per region; region r strobe = WAIT_TABLE[3r+2:3r]+1 cycles (1..8)
CNT_W, 4, width of internal cycle counter; must hold max(SETUP_CYC, HOLD_CYC, 8)

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  synchronous reset, active-high
req0  in  1  requester 0 request, level, held until ack0
sel0  in  3  requester 0 region select
ack0  out  1  one-cycle completion pulse to requester 0
req1  in  1  requester 1 request, level, held until ack1
sel1  in  3  requester 1 region select
ack1  out  1  one-cycle completion pulse to requester 1
dec_g1  out  1  to decoder G1 (active high)
dec_g2a_n  out  1  to decoder G2An
dec_g2b_n  out  1  to decoder G2Bn
dec_a  out  3  to decoder C,B,A
grant_id  out  1  requester owning current transaction
busy  out  1  high in any state except IDLE

Behaviour:
- Clock `clk`; reset `rst`, synchronous, active-high.
- Reset values: dec_g1=0, dec_g2a_n=1, dec_g2b_n=1, dec_a=0, ack0=ack1=0, grant_id=0, busy=0, state=IDLE, last_grant=1 (req0 wins first contention).
- All outputs registered; decoder never sees a glitching enable.
- States: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
- IDLE:
  - Decoder disabled (g1=0, g2a_n=g2b_n=1); dec_a holds last value.
  - Arbitrates on every edge where a req is high.
  - Single req wins outright.
  - Both high: grant the requester != last_grant (round-robin). Update last_grant and grant_id.
  - Capture sel of winner into dec_a.
  - Load counter.
  - Go SETUP, or STROBE if SETUP_CYC=0.
- SETUP: dec_g1=1, g2 enables high, for exactly SETUP_CYC cycles.
- STROBE:
  - dec_g1=1, dec_g2a_n=dec_g2b_n=0.
  - Lasts exactly WAIT_TABLE[3*sel+:3]+1 cycles, using the captured sel.
  - Only state where the decoded output is low.
- HOLD:
  - g2 enables back high, dec_g1=1, dec_a unchanged, for HOLD_CYC cycles.
  - On the last HOLD cycle, the registered ack for grant_id is high for exactly one cycle.
  - Next state IDLE.
- Transaction length from grant edge: SETUP_CYC + strobe + HOLD_CYC cycles, then at least one IDLE cycle before any new grant.
- Requester rules:
  - Requester must drop req on the cycle after ack. A req still high in the IDLE cycle after ack is a new request.
  - sel/req changes during a transaction are ignored (captured values used).
  - req dropped mid-transaction: transaction still completes and ack still pulses.
- The non-granted requester waits; its req is not lost. It is guaranteed the next grant if still asserted (starvation-free).
- rst mid-transaction:
  - Next edge forces reset values.
  - No ack is issued.
  - Strobe is aborted immediately.
- ack0 and ack1 are never high together. busy=1 from the grant edge through the ack cycle.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with req0=req1=1 -> dec_g1=0, g2 enables=1, dec_a=0, ack0=ack1=0, busy=0 throughout reset.
- Single request, defaults: req0=1, sel0=5 -> dec_a=5, g1=1 for 1 SETUP cycle, g2a_n/g2b_n=0 for 1 cycle, 1 HOLD cycle with ack0=1, total 3 busy cycles.
- Wait table: WAIT_TABLE[8:6]=3, req1=1, sel1=2 -> strobe low exactly 4 consecutive cycles, ack1 on HOLD; sel1=3 -> strobe 1 cycle.
- Contention round-robin: req0=req1=1 continuously, sel0=1, sel1=6 -> grants alternate 0,1,0,1; dec_a alternates 1,6; ack0/ack1 never coincide; at least one IDLE cycle between.
- SETUP_CYC=0, HOLD_CYC=2: req0, sel0=7 -> strobe on first busy cycle, two HOLD cycles with g1=1, ack0 on second.
- Reset mid-strobe: assert rst during STROBE of a 4-cycle region -> next cycle g2 enables=1, g1=0, no ack. After release, pending req0 is granted fresh with last_grant=1 behaviour.
